// File: rtl/peak_readout_serializer_if.sv
// rtl/peak_readout_serializer_if.sv - per-pixel peak readout stream (valid/ready beats)
interface peak_readout_serializer_if #(
  parameter int NP  = 10,
  parameter int PIX = 3,
  parameter int FW  = 8
);
  localparam int PW = $clog2(PIX);

  logic          outValid;
  logic          outReady;
  logic [NP-1:0] outData;
  logic [PW-1:0] outPixel;
  logic [FW-1:0] outFrame;
  logic          outLast;

  modport master (
    output outValid, outData, outPixel, outFrame, outLast,
    input  outReady
  );

  modport slave (
    input  outValid, outData, outPixel, outFrame, outLast,
    output outReady
  );
endinterface

// File: rtl/peak_readout_serializer.sv
// rtl/peak_readout_serializer.sv - two-slot peak frame buffer serialised one pixel per beat
module peak_readout_serializer #(
  parameter int NP  = 10,
  parameter int PIX = 3,
  parameter int FW  = 8
) (
  input  logic                clk,
  input  logic                res,
  input  logic                peakValid,
  input  logic [NP*PIX-1:0]   peakIn,
  input  logic                clrOvf,
  output logic                overflow,
  peak_readout_serializer_if.master stream
);
  localparam int PW = $clog2(PIX);
  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    SEND     = 1'b1;
  localparam logic [PW-1:0] LAST_PIX = PW'(PIX - 1);

  logic [0:0]        state;
  logic [NP*PIX-1:0] slot_data [2];
  logic [FW-1:0]     slot_tag  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic [1:0]        occ_next;
  logic [PW-1:0]     pix;
  logic [FW-1:0]     frame_cnt;

  logic sending;
  logic fire;
  logic last_fire;
  logic accept;
  logic drop;

  assign sending   = (state == SEND);
  assign fire      = sending && stream.outReady;
  assign last_fire = fire && (pix == LAST_PIX);
  // A full buffer still accepts when its read slot is freed on this very edge.
  assign accept    = peakValid && ((occ != 2'd2) || last_fire);
  assign drop      = peakValid && !accept;

  always_comb begin
    occ_next = occ;
    if (accept && !last_fire)
      occ_next = occ + 2'd1;
    else if (!accept && last_fire)
      occ_next = occ - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state     <= IDLE;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      pix       <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      occ <= occ_next;
      if (peakValid)
        frame_cnt <= frame_cnt + FW'(1);
      if (accept)
        wr_ptr <= ~wr_ptr;
      if (last_fire)
        rd_ptr <= ~rd_ptr;
      if (drop)
        overflow <= 1'b1;
      else if (clrOvf)
        overflow <= 1'b0;

      case (state)
        IDLE: begin
          pix <= '0;
          if (occ != 2'd0)
            state <= SEND;
        end
        SEND: begin
          if (fire) begin
            if (last_fire) begin
              pix <= '0;
              // Stay in SEND when the other slot holds a frame: no bubble between frames.
              if (occ_next == 2'd0)
                state <= IDLE;
            end else begin
              pix <= pix + PW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res && accept) begin
      slot_data[wr_ptr] <= peakIn;
      slot_tag[wr_ptr]  <= frame_cnt;
    end
  end

  // Outputs are muxed only by registered state, rd_ptr and pix.
  assign stream.outValid = sending;
  assign stream.outData  = sending ? slot_data[rd_ptr][int'(pix)*NP +: NP] : '0;
  assign stream.outPixel = sending ? pix : '0;
  assign stream.outFrame = sending ? slot_tag[rd_ptr] : '0;
  assign stream.outLast  = sending && (pix == LAST_PIX);
endmodule

// File: tb/tb_peak_readout_serializer.sv
// tb/tb_peak_readout_serializer.sv - directed self-checking bench for peak_readout_serializer
module tb_peak_readout_serializer;
  localparam int NP  = 10;
  localparam int PIX = 3;
  localparam int FW  = 8;

  logic             clk = 1'b0;
  logic             res;
  logic             peakValid;
  logic [NP*PIX-1:0] peakIn;
  logic             clrOvf;
  logic             overflow;

  int n_checks = 0;
  int n_pass   = 0;

  peak_readout_serializer_if #(.NP(NP), .PIX(PIX), .FW(FW)) sif ();

  peak_readout_serializer #(.NP(NP), .PIX(PIX), .FW(FW)) dut (
    .clk       (clk),
    .res       (res),
    .peakValid (peakValid),
    .peakIn    (peakIn),
    .clrOvf    (clrOvf),
    .overflow  (overflow),
    .stream    (sif)
  );

  always #5 clk = ~clk;

  function automatic logic [NP*PIX-1:0] frame3(input int p2, input int p1, input int p0);
    return {NP'(p2), NP'(p1), NP'(p0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res       = 1'b0;
    peakValid = 1'b0;
    clrOvf    = 1'b0;
    tick();
    res = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(sif.outValid), 0);
    check({tag, "_last"},  32'(sif.outLast),  0);
  endtask

  // Checks one full frame with outReady held high; first beat must already be visible.
  task automatic check_frame(input string tag, input int frame, input int d0, input int d1, input int d2);
    int d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    sif.outReady = 1'b1;
    for (int p = 0; p < PIX; p++) begin
      check({tag, "_valid"}, 32'(sif.outValid), 1);
      check({tag, "_data"},  32'(sif.outData),  32'(d[p]));
      check({tag, "_pix"},   32'(sif.outPixel), 32'(p));
      check({tag, "_frame"}, 32'(sif.outFrame), 32'(frame));
      check({tag, "_last"},  32'(sif.outLast),  32'(p == PIX - 1));
      tick();
      peakValid = 1'b0;
    end
  endtask

  initial begin
    res          = 1'b0;
    peakValid    = 1'b1;
    peakIn       = frame3(1023, 511, 108);
    clrOvf       = 1'b0;
    sif.outReady = 1'b1;

    // Reset held with peakValid high: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_valid", 32'(sif.outValid), 0);
      check("rst_data",  32'(sif.outData),  0);
      check("rst_pix",   32'(sif.outPixel), 0);
      check("rst_frame", 32'(sif.outFrame), 0);
      check("rst_last",  32'(sif.outLast),  0);
      check("rst_ovf",   32'(overflow),     0);
    end

    // Single frame: first strobe after release carries tag 0, one-cycle latency.
    res = 1'b1;
    tick();
    peakValid = 1'b0;
    check("single_latency", 32'(sif.outValid), 0);
    tick();
    check_frame("single", 0, 108, 511, 1023);
    check_idle("single_end");

    // Backpressure on p1 for 4 cycles.
    do_reset();
    peakIn = frame3(300, 200, 100);
    peakValid = 1'b1;
    tick();
    peakValid = 1'b0;
    tick();
    check("bp_p0_data", 32'(sif.outData), 100);
    tick();
    check("bp_p1_data", 32'(sif.outData), 200);
    sif.outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", 32'(sif.outValid), 1);
      check("bp_hold_data",  32'(sif.outData),  200);
      check("bp_hold_pix",   32'(sif.outPixel), 1);
      check("bp_hold_frame", 32'(sif.outFrame), 0);
      check("bp_hold_last",  32'(sif.outLast),  0);
    end
    sif.outReady = 1'b1;
    tick();
    check("bp_p2_data", 32'(sif.outData),  300);
    check("bp_p2_pix",  32'(sif.outPixel), 2);
    check("bp_p2_last", 32'(sif.outLast),  1);
    tick();
    check_idle("bp_end");

    // Two frames strobed 2 cycles apart stream back to back.
    do_reset();
    peakIn = frame3(30, 20, 10);
    peakValid = 1'b1;
    tick();
    peakValid = 1'b0;
    tick();
    peakIn = frame3(60, 50, 40);
    peakValid = 1'b1;
    check_frame("two_a", 0, 10, 20, 30);
    check_frame("two_b", 1, 40, 50, 60);
    check_idle("two_end");

    // Overflow: third strobe into a full, stalled buffer is dropped.
    do_reset();
    sif.outReady = 1'b0;
    peakValid = 1'b1;
    peakIn = frame3(3, 2, 1);
    tick();
    peakIn = frame3(6, 5, 4);
    tick();
    peakIn = frame3(33, 22, 11);
    check("ovf_before", 32'(overflow), 0);
    tick();
    peakValid = 1'b0;
    check("ovf_set",        32'(overflow),     1);
    check("ovf_hold_frame", 32'(sif.outFrame), 0);
    check("ovf_hold_pix",   32'(sif.outPixel), 0);
    check_frame("ovf_a", 0, 1, 2, 3);
    check_frame("ovf_b", 1, 4, 5, 6);
    check_idle("ovf_drain");
    peakIn = frame3(9, 8, 7);
    peakValid = 1'b1;
    tick();
    peakValid = 1'b0;
    tick();
    check_frame("ovf_gap", 3, 7, 8, 9);
    check("ovf_sticky", 32'(overflow), 1);
    clrOvf = 1'b1;
    tick();
    clrOvf = 1'b0;
    check("ovf_clear", 32'(overflow), 0);
    sif.outReady = 1'b0;
    peakValid = 1'b1;
    tick();
    tick();
    clrOvf = 1'b1;
    tick();
    clrOvf = 1'b0;
    peakValid = 1'b0;
    check("ovf_set_wins", 32'(overflow), 1);
    sif.outReady = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check_idle("ovf_end");

    // Capture coinciding with the final beat of a full buffer is accepted.
    do_reset();
    sif.outReady = 1'b0;
    peakValid = 1'b1;
    peakIn = frame3(13, 12, 11);
    tick();
    peakIn = frame3(16, 15, 14);
    tick();
    peakValid = 1'b0;
    check("col_p0_data", 32'(sif.outData), 11);
    sif.outReady = 1'b1;
    tick();
    tick();
    check("col_p2_last", 32'(sif.outLast), 1);
    peakIn = frame3(19, 18, 17);
    peakValid = 1'b1;
    tick();
    peakValid = 1'b0;
    check("col_ovf", 32'(overflow), 0);
    check_frame("col_b", 1, 14, 15, 16);
    check("col_c_valid", 32'(sif.outValid), 1);
    check("col_c_frame", 32'(sif.outFrame), 2);
    check("col_c_data",  32'(sif.outData),  17);
    tick();
    check("col_c_pix1", 32'(sif.outPixel), 1);

    // Reset mid-frame discards everything.
    res = 1'b0;
    tick();
    res = 1'b1;
    check("mid_rst_valid", 32'(sif.outValid), 0);
    check("mid_rst_data",  32'(sif.outData),  0);
    check("mid_rst_frame", 32'(sif.outFrame), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_rst_stale", 32'(sif.outValid), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
